// File: rtl/program_loader.sv
// Load-run-fetch sequencer: streams instruction words into the unified memory, kicks the core,
// then reads back the answer word. Optional RUN watchdog is enabled by defining RUN_TIMEOUT_EN.
module program_loader #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int RESULT_ADDR = 31,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              write_ins,
  output logic [ADDR_W-1:0] ins_address,
  output logic [DATA_W-1:0] ins,
  output logic              cpu_start,
  input  logic              cpu_done,
  output logic [ADDR_W-1:0] result_add,
  input  logic [DATA_W-1:0] resultado_out,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              busy,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_STROBE,
    S_START,
    S_RUN,
    S_FETCH,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0]   MAX_COUNT = (ADDR_W + 1)'(2 ** ADDR_W);
  localparam logic [ADDR_W-1:0] RES_ADDR  = ADDR_W'(RESULT_ADDR);

  state_t            state;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   idx_next;
  logic [ADDR_W:0]   count_sat;

`ifdef RUN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] run_cyc;
`endif

  // idx is one bit wider than the address so a full 2**ADDR_W word load can terminate.
  assign idx_next  = idx + (ADDR_W + 1)'(1);
  assign count_sat = (count > MAX_COUNT) ? MAX_COUNT : count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      count_q      <= '0;
      base_q       <= '0;
      in_ready     <= 1'b0;
      write_ins    <= 1'b0;
      ins_address  <= '0;
      ins          <= '0;
      cpu_start    <= 1'b0;
      result_add   <= RES_ADDR;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
`ifdef RUN_TIMEOUT_EN
      run_cyc      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            error   <= 1'b0;
            base_q  <= base_addr;
            count_q <= count_sat;
            idx     <= '0;
            if (count_sat == '0) begin
              cpu_start <= 1'b1;
              state     <= S_START;
            end else begin
              in_ready <= 1'b1;
              state    <= S_LOAD;
            end
          end
        end

        // ins/ins_address only move here, so they settle a full cycle before the strobe.
        S_LOAD: begin
          if (in_valid) begin
            ins         <= in_data;
            ins_address <= base_q + idx[ADDR_W-1:0];
            in_ready    <= 1'b0;
            state       <= S_SETUP;
          end
        end

        S_SETUP: begin
          write_ins <= 1'b1;
          state     <= S_STROBE;
        end

        S_STROBE: begin
          write_ins <= 1'b0;
          idx       <= idx_next;
          if (idx_next == count_q) begin
            cpu_start <= 1'b1;
            state     <= S_START;
          end else begin
            in_ready <= 1'b1;
            state    <= S_LOAD;
          end
        end

        S_START: begin
          cpu_start <= 1'b0;
          state     <= S_RUN;
`ifdef RUN_TIMEOUT_EN
          run_cyc   <= TW'(1);
`endif
        end

        // run_cyc counts cycles since cpu_start rose; the watchdog fires TIMEOUT_CYC cycles after it.
        S_RUN: begin
          if (cpu_done) begin
            state <= S_FETCH;
`ifdef RUN_TIMEOUT_EN
          end else if (run_cyc >= TW'(TIMEOUT_CYC - 1)) begin
            error <= 1'b1;
            state <= S_FETCH;
          end else begin
            run_cyc <= run_cyc + TW'(1);
`endif
          end
        end

        S_FETCH: begin
          result_add   <= RES_ADDR;
          result       <= resultado_out;
          result_valid <= 1'b1;
          state        <= S_DONE;
        end

        S_DONE: begin
          result_valid <= 1'b0;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a behavioural 32x32 memory, directed jobs, and a negedge
// monitor that checks every write strobe and result pulse against queued expectations.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  base_addr = '0;
  logic [5:0]  count = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        write_ins;
  logic [4:0]  ins_address;
  logic [31:0] ins;
  logic        cpu_start;
  logic        cpu_done = 1'b0;
  logic [4:0]  result_add;
  logic [31:0] resultado_out;
  logic [31:0] result;
  logic        result_valid;
  logic        busy;
  logic        error;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] res_q[$];
  logic [31:0] mem [0:31];
  logic [31:0] words [0:31];
  int          n_compared = 0;
  int          n_mismatched = 0;
  logic        prev_wr = 1'b0;
  logic [4:0]  prev_addr = '0;
  logic [31:0] prev_ins = '0;

  program_loader #(
    .ADDR_W(5), .DATA_W(32), .RESULT_ADDR(31), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .write_ins(write_ins),
    .ins_address(ins_address), .ins(ins), .cpu_start(cpu_start), .cpu_done(cpu_done),
    .result_add(result_add), .resultado_out(resultado_out), .result(result),
    .result_valid(result_valid), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // Memory captures on the rising edge of the write strobe; the result port reads combinationally.
  always @(posedge write_ins) mem[ins_address] = ins;
  assign resultado_out = mem[result_add];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each write_ins rising edge and each result pulse.
  always @(negedge clk) begin
    if (write_ins && !prev_wr) begin
      if (wr_q.size() == 0) begin
        checkOutput("unexpected_write", {27'd0, ins_address, ins}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        checkOutput("write_addr", 64'(ins_address), 64'(e.a));
        checkOutput("write_data", 64'(ins), 64'(e.d));
        checkOutput("write_stable", {27'd0, prev_addr, prev_ins}, {27'd0, ins_address, ins});
      end
    end
    if (result_valid) begin
      if (res_q.size() == 0) begin
        checkOutput("unexpected_result", 64'(result), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        checkOutput("result", 64'(result), 64'(res_q.pop_front()));
      end
    end
    prev_wr   <= write_ins;
    prev_addr <= ins_address;
    prev_ins  <= ins;
  end

  // One full job: start, feed n_words words (optional 10-cycle stall after gap_after), run, fetch.
  task automatic applyStimulus(input logic [4:0] base, input logic [5:0] cnt, input int n_words,
                               input int gap_after, input logic [31:0] ans, input bit send_done);
    int t;
    int ok_cnt;
    @(negedge clk);
    base_addr = base;
    count     = cnt;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    checkOutput("error_cleared", 64'(error), 64'd0);
    if (n_words == 0) checkOutput("cpu_start_latency", 64'(cpu_start), 64'd1);
    for (int w = 0; w < n_words; w++) begin
      if (w == gap_after) begin
        t = 0;
        while (!in_ready && t < 20) begin @(negedge clk); t++; end
        ok_cnt = 0;
        for (int g = 0; g < 10; g++) begin
          if (in_ready && !write_ins && busy) ok_cnt++;
          start = (g == 4);
          @(negedge clk);
        end
        start = 1'b0;
        checkOutput("stall_ready_held", 64'(ok_cnt), 64'd10);
      end
      wr_q.push_back('{a: base + 5'(w), d: words[w]});
      in_valid = 1'b1;
      in_data  = words[w];
      t = 0;
      while (!in_ready && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
    end
    t = 0;
    while (!cpu_start && t < 20) begin @(negedge clk); t++; end
    checkOutput("cpu_start_seen", 64'(cpu_start), 64'd1);
    checkOutput("writes_drained", 64'(wr_q.size()), 64'd0);
    mem[31] = ans;
    res_q.push_back(ans);
    @(negedge clk);
    t = 1;
    checkOutput("cpu_start_one_cycle", 64'(cpu_start), 64'd0);
    if (send_done) begin
      repeat (3) @(negedge clk);
      cpu_done = 1'b1;
      @(negedge clk);
      cpu_done = 1'b0;
    end else begin
      while (!error && t < 200) begin @(negedge clk); t++; end
      checkOutput("timeout_cycles", 64'(t), 64'd16);
    end
    t = 0;
    while (busy && t < 50) begin @(negedge clk); t++; end
    checkOutput("job_finished", 64'(busy), 64'd0);
    checkOutput("result_consumed", 64'(res_q.size()), 64'd0);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_ctrl", {58'd0, in_ready, write_ins, cpu_start, result_valid, busy, error}, 64'd0);
    checkOutput("reset_result_add", 64'(result_add), 64'd31);
    checkOutput("reset_result", 64'(result), 64'd0);

    // Basic three-word load at address 0.
    words[0] = 32'hA0A0_0001; words[1] = 32'hB0B0_0002; words[2] = 32'hC0C0_0003;
    applyStimulus(5'd0, 6'd3, 3, -1, 32'h1111_2222, 1'b1);

    // Address wrap: 30,31,0,1.
    words[0] = 32'h3000_0030; words[1] = 32'h3100_0031; words[2] = 32'h0000_0100; words[3] = 32'h0100_0101;
    applyStimulus(5'd30, 6'd4, 4, -1, 32'hDEAD_BEEF, 1'b1);

    // Empty load goes straight to cpu_start.
    applyStimulus(5'd7, 6'd0, 0, -1, 32'h0000_002A, 1'b1);

    // Upstream stall mid-load with an ignored start pulse.
    words[0] = 32'h4444_0000; words[1] = 32'h4444_0001; words[2] = 32'h4444_0002; words[3] = 32'h4444_0003;
    applyStimulus(5'd8, 6'd4, 4, 2, 32'h5555_AAAA, 1'b1);

    // Oversized count saturates to a full 32-word load.
    for (int i = 0; i < 32; i++) words[i] = 32'h7000_0000 + 32'(i * 3);
    applyStimulus(5'd3, 6'd40, 32, -1, 32'h0BAD_F00D, 1'b1);

    // Reset asserted while write_ins is high.
    @(negedge clk);
    base_addr = 5'd5; count = 6'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_q.push_back('{a: 5'd5, d: 32'h6666_0005});
    in_valid = 1'b1; in_data = 32'h6666_0005;
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!write_ins && t < 20) begin @(negedge clk); t++; end
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_mid_write_ins", 64'(write_ins), 64'd0);
    checkOutput("reset_mid_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("partial_write_seen", 64'(wr_q.size()), 64'd0);
    words[0] = 32'h9000_0001; words[1] = 32'h9000_0002;
    applyStimulus(5'd12, 6'd2, 2, -1, 32'h1234_5678, 1'b1);
    checkOutput("error_default", 64'(error), 64'd0);

`ifdef RUN_TIMEOUT_EN
    applyStimulus(5'd0, 6'd0, 0, -1, 32'hFEED_0016, 1'b0);
    checkOutput("error_sticky", 64'(error), 64'd1);
    applyStimulus(5'd0, 6'd0, 0, -1, 32'h0000_0777, 1'b1);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
